// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide, one bit per cycle, stalls EX until done
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mulop,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam int CW = $clog2(XLEN);
    state_t state, state_nxt;
    logic [CW-1:0] count;
    logic [XLEN-1:0] a, b, mag1, mag2, special, final_res, quot, rem;
    logic [2*XLEN-1:0] acc, acc_nxt, prod;
    logic [XLEN:0] sum, sh, diff;
    logic [2:0] op;
    logic neg, sign_a, sa, sb, accept, div_zero, ovf, last;
    always_comb begin
        sa = rs1[XLEN-1] & (mulop[2] ? ~mulop[0] : (mulop[1:0] == 2'd1 || mulop[1:0] == 2'd2));
        sb = rs2[XLEN-1] & (mulop[2] ? ~mulop[0] : (mulop[1:0] == 2'd1));
        mag1 = sa ? -rs1 : rs1;
        mag2 = sb ? -rs2 : rs2;
        div_zero = rs2 == '0;
        ovf = mulop[2] && !mulop[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && (&rs2);
        special = div_zero ? (mulop[1] ? rs1 : '1) : (mulop[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
        accept = state == IDLE && start && !flush;
        busy = state == MUL || state == DIV;
        stall = accept || busy;
        done = state == DONE;
        last = count == CW'(XLEN-1);
        // multiply: accumulator high half gathers partial sums, low half shifts the multiplier out
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a} : '0);
        // divide: {rem, quot} shifts left, a non-negative trial difference sets the quotient bit
        sh = acc[2*XLEN-1:XLEN-1];
        diff = sh - {1'b0, b};
        acc_nxt = state == MUL ? {sum, acc[XLEN-1:1]}
                               : {diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], ~diff[XLEN]};
        prod = neg ? -acc_nxt : acc_nxt;
        quot = neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem = sign_a ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        final_res = op[2] ? (op[1] ? rem : quot) : (op[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = IDLE;
        else
            case (state)
                IDLE: if (start) state_nxt = !mulop[2] ? MUL : (div_zero || ovf) ? DONE : DIV;
                MUL, DIV: if (last) state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            result <= '0;
            acc <= '0;
            a <= '0;
            b <= '0;
            op <= '0;
            neg <= 1'b0;
            sign_a <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a <= mag1;
                b <= mag2;
                op <= mulop;
                neg <= sa ^ sb;
                sign_a <= sa;
                count <= '0;
                acc <= {{XLEN{1'b0}}, mulop[2] ? mag1 : mag2};
                if (mulop[2] && (div_zero || ovf)) result <= special;
            end else if (busy) begin
                acc <= acc_nxt;
                count <= count + 1'b1;
                if (last && !flush) result <= final_res;
            end
        end
    end
endmodule
